// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector with a runtime-loadable W-bit pattern (MSB oldest),
// selectable overlapping / non-overlapping detection, an in_valid qualifier
// for gapped streams, and a saturating match counter.
module seq_detector_param #(
  parameter int              W               = 4,
  parameter int              CNT_W           = 8,
  parameter logic [W-1:0]    DEFAULT_PATTERN = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int             FW        = $clog2(W + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(W);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]       state_q, state_n;
  logic [W-1:0]     hist_q, hist_n;
  logic [FW-1:0]    fill_q, fill_n;
  logic [W-1:0]     pattern_q, pattern_n;
  logic             overlap_q, overlap_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             match_q;
  logic             hit;

  logic [W-1:0]     shifted;
  logic [FW-1:0]    fill_inc;

  // Candidate history / fill for an accepted bit.
  always_comb begin
    shifted  = {hist_q[W-2:0], in_bit};
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
  end

  // Next-state logic: cfg_load outranks in_valid; idle cycles hold everything.
  always_comb begin
    hist_n    = hist_q;
    fill_n    = fill_q;
    pattern_n = pattern_q;
    overlap_n = overlap_q;
    hit       = 1'b0;

    if (cfg_load) begin
      pattern_n = cfg_pattern;
      overlap_n = cfg_overlap;
      hist_n    = '0;
      fill_n    = '0;
    end else if (in_valid) begin
      hit = (fill_inc == FILL_FULL) && (shifted == pattern_q);
      if (hit && !overlap_q) begin
        // Non-overlapping: the completed match consumes the whole history.
        hist_n = '0;
        fill_n = '0;
      end else begin
        hist_n = shifted;
        fill_n = fill_inc;
      end
    end
  end

  // FSM tracks whether the history is full; derived from the next fill level.
  always_comb begin
    state_n = (fill_n == FILL_FULL) ? ARMED : FILL;
  end

  // Saturating counter; a clear in the same cycle as a hit wins.
  always_comb begin
    count_n = count_q;
    if (clr_count) begin
      count_n = '0;
    end else if (hit && (count_q != '1)) begin
      count_n = count_q + 1'b1;
    end
  end

  // State registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEFAULT_PATTERN;
      overlap_q <= 1'b1;
      count_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      hist_q    <= hist_n;
      fill_q    <= fill_n;
      pattern_q <= pattern_n;
      overlap_q <= overlap_n;
      count_q   <= count_n;
      match_q   <= hit;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign armed       = (state_q == ARMED);

endmodule
